dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a multi-cycle off-chip data memory.
- Accepts one word load/store per cycle from the MEM stage.
- Asserts a stall toward the pipeline on a miss.
- Runs line write-back and refill transactions with a req/ack handshake.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2); index width IDX_W = log2(NUM_LINES) = 4.
- LINE_BYTES, 32, bytes per line; line width 256 bits, 8 words, offset bits [4:0].
- ADDR_W, 32, byte address width; tag width = ADDR_W - IDX_W - 5 = 23.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address (ALU result); bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, valid when cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze PC and all pipeline registers.
- mem_req_o  out  1  memory transaction request, held until ack.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0.
- mem_data_o  out  256  victim line for write-back.
- mem_data_i  in  256  refill line, valid in the mem_ack_i cycle.
- mem_ack_i  in  1  single-cycle completion pulse.

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
- hit = valid[index] && tag_array[index]==tag.
- Reset (rst_i=1 at an edge):
  - valid/dirty arrays cleared, state=IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0, cpu_data_o=0.
  - Tag and data arrays are not cleared.
- Reset mid-transaction abandons it; mem_req_o is low the cycle after reset. A late mem_ack_i while in IDLE is ignored.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE, cpu_req_i=0: stall=0, no array change.
- IDLE, hit (combinational, zero latency): stall=0.
  - Load: cpu_data_o = word of line.
  - Store: word written at the edge, dirty[index]=1.
- IDLE, miss: stall=1 in the same cycle.
  - If valid&&dirty: next=WRITEBACK, else next=ALLOCATE.
  - mem_req_o rises the following cycle (registered outputs).
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={old_tag,index,5'b0}, mem_data_o=line.
  - On mem_ack_i: next=ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,5'b0}.
  - On mem_ack_i: line<=mem_data_i, tag<=tag, valid=1, dirty=0; next=REFILL.
- REFILL: stall=1, mem_req_o=0 for one cycle, then IDLE.
  - The retried access then hits; a store merges and sets dirty.
- stall stays 1 from the miss cycle through REFILL inclusive; it drops in the IDLE cycle where the hit is serviced.
- Miss penalty: latency = 1 (detect) + WB_cycles + FETCH_cycles + 1 (REFILL).
- CPU contract: cpu_req_i/we/addr/data are held stable while stall=1. A change of them during a miss is a protocol violation and need not be handled.
- mem_ack_i while mem_req_o=0: ignored.
- mem_ack_i in the same cycle mem_req_o first rises: accepted.
- Indices wrap naturally; addresses differing only in the tag conflict on the same line.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE, REFILL).
  - localparams TAG_W, IDX_W, OFF_W, LINE_W, WORD_SEL_W.
  - address-field helper functions.
- One sub-module dcache_array: tag/valid/dirty/data storage.
  - Combinational read.
  - Synchronous write: word write with byte-lane mux, or full-line write.
  - Synchronous clear of valid/dirty on rst_i.
- The controller FSM and hit logic live in dcache_controller.

Test Plan:
- Cold load 0x0000_0104 with memory returning line 0x..._AAAA after 3-cycle ack delay:
  - no write-back.
  - mem_addr_o = 0x0000_0100, mem_we_o=0.
  - stall high 5 cycles.
  - cpu_data_o = word 1 of line.
- Load hit after the above at 0x0000_0108 → stall=0, data in the same cycle, no mem_req_o.
- Store 0xDEADBEEF to 0x0000_0104 (hit) → no stall, dirty set. Then load 0x0000_0104 → 0xDEADBEEF.
- Conflict load 0x0000_0304 (same index 8, tag differs) on the dirty line:
  - WRITEBACK first, mem_addr_o=0x0000_0100, mem_data_o word 1 = 0xDEADBEEF.
  - Then fetch at 0x0000_0300.
- Store miss to a clean invalid line 0x0000_1FE0 (index 15):
  - ALLOCATE only.
  - After REFILL, word 0 = store data, dirty=1, other 7 words from mem_data_i.
- rst_i asserted during ALLOCATE:
  - next cycle mem_req_o=0, stall=0.
  - Subsequent load to the same address misses again (valid cleared).
  - A stray ack arriving after reset is ignored.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, geometry and address helpers for the data cache.
//   - state_e      : controller FSM states
//   - TAG_W/IDX_W/OFF_W/LINE_W/WORD_SEL_W : address split and line geometry
//   - addr_tag/addr_idx/addr_word/line_addr/line_word : field helpers
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int NUM_LINES  = 16;
    localparam int IDX_W      = 4;
    localparam int OFF_W      = 5;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W     = 256;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WORD_SEL_W];
    endfunction

    // Rebuild a line-aligned byte address from its tag and index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                              input logic [WORD_SEL_W-1:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/dirty/data storage for the direct-mapped cache.
//   clk, rst          : clock, synchronous active-high clear of valid/dirty
//   idx               : line index for both the combinational read and writes
//   rd_valid/rd_dirty/rd_tag/rd_line : combinational read of line idx
//   word_we/word_sel/word_be/word_data : store one word (byte-lane masked), sets dirty
//   line_we/line_tag/line_data : refill a whole line, sets valid, clears dirty
// Tag and data storage are deliberately not reset.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [3:0]            word_be,
    input  logic [31:0]           word_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_W-1:0]     line_data
);

    logic [NUM_LINES-1:0] valid_r;
    logic [NUM_LINES-1:0] dirty_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [LINE_W-1:0]    data_r [NUM_LINES];
    logic [LINE_W-1:0]    merged_s;

    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_tag   = tag_r[idx];
    assign rd_line  = data_r[idx];

    // Byte-lane merge of the store word into the currently stored line.
    always_comb begin
        merged_s = data_r[idx];
        for (int b = 0; b < 4; b++) begin
            if (word_be[b]) begin
                merged_s[{word_sel, 2'(b), 3'b000} +: 8] = word_data[b*8 +: 8];
            end else begin
                merged_s[{word_sel, 2'(b), 3'b000} +: 8] = data_r[idx][{word_sel, 2'(b), 3'b000} +: 8];
            end
        end
    end

    // Valid/dirty flags: cleared on reset, refill validates clean, store dirties.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (line_we) begin
            valid_r[idx] <= 1'b1;
            dirty_r[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_r[idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_r[idx]  <= line_tag;
            data_r[idx] <= line_data;
        end else if (word_we) begin
            data_r[idx] <= merged_s;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i : MEM-stage access (held while stalled)
//   cpu_data_o, cpu_stall_o : zero-latency hit data, pipeline freeze
//   mem_req_o/mem_we_o/mem_addr_o/mem_data_o : registered line transaction request
//   mem_data_i, mem_ack_i   : refill line and single-cycle completion pulse
// Hits are serviced combinationally in IDLE; a miss walks
// IDLE -> [WRITEBACK] -> ALLOCATE -> REFILL -> IDLE and the retried access hits.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    logic [TAG_W-1:0]      req_tag_s;
    logic [IDX_W-1:0]      req_idx_s;
    logic [WORD_SEL_W-1:0] req_word_s;
    logic                  unused_addr_s;

    logic                  rd_valid_s;
    logic                  rd_dirty_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [LINE_W-1:0]     rd_line_s;
    logic                  hit_s;

    state_e                state_r;
    state_e                state_next_s;
    logic                  stall_s;
    logic [31:0]           load_data_s;
    logic                  word_we_s;
    logic                  line_we_s;

    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [31:0]           mem_addr_r;
    logic [LINE_W-1:0]     mem_data_r;
    logic                  mem_req_next_s;
    logic                  mem_we_next_s;
    logic [31:0]           mem_addr_next_s;
    logic [LINE_W-1:0]     mem_data_next_s;

    assign req_tag_s     = addr_tag(cpu_addr_i);
    assign req_idx_s     = addr_idx(cpu_addr_i);
    assign req_word_s    = addr_word(cpu_addr_i);
    assign unused_addr_s = ^cpu_addr_i[1:0];

    dcache_array u_array (
        .clk       (clk_i),
        .rst       (rst_i),
        .idx       (req_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .word_we   (word_we_s),
        .word_sel  (req_word_s),
        .word_be   (4'b1111),
        .word_data (cpu_data_i),
        .line_we   (line_we_s),
        .line_tag  (req_tag_s),
        .line_data (mem_data_i)
    );

    assign hit_s = rd_valid_s && (rd_tag_s == req_tag_s);

    // Next state, hit servicing and next values of the registered memory outputs.
    always_comb begin
        state_next_s    = state_r;
        stall_s         = 1'b0;
        load_data_s     = 32'd0;
        word_we_s       = 1'b0;
        line_we_s       = 1'b0;
        mem_req_next_s  = 1'b0;
        mem_we_next_s   = 1'b0;
        mem_addr_next_s = 32'd0;
        mem_data_next_s = '0;
        case (state_r)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit_s) begin
                        if (cpu_we_i) begin
                            word_we_s = 1'b1;
                        end else begin
                            load_data_s = line_word(rd_line_s, req_word_s);
                        end
                    end else begin
                        stall_s        = 1'b1;
                        mem_req_next_s = 1'b1;
                        if (rd_valid_s && rd_dirty_s) begin
                            // Victim is captured now; the array still holds it until refill.
                            state_next_s    = WRITEBACK;
                            mem_we_next_s   = 1'b1;
                            mem_addr_next_s = line_addr(rd_tag_s, req_idx_s);
                            mem_data_next_s = rd_line_s;
                        end else begin
                            state_next_s    = ALLOCATE;
                            mem_addr_next_s = line_addr(req_tag_s, req_idx_s);
                        end
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITEBACK: begin
                stall_s        = 1'b1;
                mem_req_next_s = 1'b1;
                if (mem_ack_i) begin
                    state_next_s    = ALLOCATE;
                    mem_addr_next_s = line_addr(req_tag_s, req_idx_s);
                end else begin
                    mem_we_next_s   = 1'b1;
                    mem_addr_next_s = mem_addr_r;
                    mem_data_next_s = mem_data_r;
                end
            end
            ALLOCATE: begin
                stall_s = 1'b1;
                if (mem_ack_i) begin
                    line_we_s    = 1'b1;
                    state_next_s = REFILL;
                end else begin
                    mem_req_next_s  = 1'b1;
                    mem_addr_next_s = mem_addr_r;
                end
            end
            REFILL: begin
                stall_s      = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and memory-side output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_data_r <= '0;
        end else begin
            state_r    <= state_next_s;
            mem_req_r  <= mem_req_next_s;
            mem_we_r   <= mem_we_next_s;
            mem_addr_r <= mem_addr_next_s;
            mem_data_r <= mem_data_next_s;
        end
    end

    assign cpu_stall_o = stall_s;
    assign cpu_data_o  = load_data_s;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_data_o  = mem_data_r;

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed, table-driven bench for dcache_controller.
// Memory lines follow line_pat(): word w of the line at address A is {A[15:0], 16'hAAA0+w}.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks   = 0;
    int failures = 0;

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = {a[15:0], 16'hAAA0 + 16'(w)};
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        cpu_req_i  = req;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
    endtask

    // Walk a miss from its detect cycle through REFILL; ack arrives on the first
    // WRITEBACK cycle and on the delay-th ALLOCATE cycle. Ends in the retry cycle.
    task automatic serve_miss(input string name, input logic exp_wb,
                              input logic [31:0] wb_addr, input int wb_w,
                              input logic [31:0] wb_val, input logic [31:0] fetch_addr,
                              input int delay, input int exp_stall_cycles);
        int stalls;
        stalls = 0;
        @(negedge clk_i);
        chk({name, "_detect_stall"}, 256'(cpu_stall_o), 256'(1'b1));
        chk({name, "_detect_noreq"}, 256'(mem_req_o), 256'(1'b0));
        stalls += int'(cpu_stall_o);
        next_cycle();
        if (exp_wb) begin
            @(negedge clk_i);
            chk({name, "_wb_req_we"}, 256'({mem_req_o, mem_we_o}), 256'(2'b11));
            chk({name, "_wb_addr"}, 256'(mem_addr_o), 256'(wb_addr));
            chk({name, "_wb_word"}, 256'(mem_data_o[wb_w*32 +: 32]), 256'(wb_val));
            stalls += int'(cpu_stall_o);
            mem_ack_i = 1'b1;
            next_cycle();
            mem_ack_i = 1'b0;
        end
        for (int c = 0; c < delay; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                chk({name, "_fetch_req_we"}, 256'({mem_req_o, mem_we_o}), 256'(2'b10));
                chk({name, "_fetch_addr"}, 256'(mem_addr_o), 256'(fetch_addr));
            end
            stalls += int'(cpu_stall_o);
            if (c == delay - 1) begin
                mem_ack_i  = 1'b1;
                mem_data_i = line_pat(fetch_addr);
            end
            next_cycle();
            mem_ack_i = 1'b0;
        end
        @(negedge clk_i);
        chk({name, "_refill_noreq"}, 256'(mem_req_o), 256'(1'b0));
        stalls += int'(cpu_stall_o);
        chk({name, "_stall_cycles"}, 256'(stalls), 256'(exp_stall_cycles));
        next_cycle();
    endtask

    vec_t hit_vecs[8];

    initial begin
        hit_vecs[0] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         1'b0, 1'b1, 32'h0100_AAA2};
        hit_vecs[1] = '{1'b1, 1'b0, 32'h0000_011C, 32'h0,         1'b0, 1'b1, 32'h0100_AAA7};
        hit_vecs[2] = '{1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        hit_vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        hit_vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 1'b1, 32'h0};
        hit_vecs[5] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 32'h0100_AAA0};
        hit_vecs[6] = '{1'b1, 1'b1, 32'h0000_0110, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        hit_vecs[7] = '{1'b1, 1'b0, 32'h0000_0111, 32'h0,         1'b0, 1'b1, 32'h1234_5678};

        rst_i      = 1'b1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_stall", 256'(cpu_stall_o), 256'(1'b0));
        chk("reset_mem_req_we", 256'({mem_req_o, mem_we_o}), 256'(2'b00));
        chk("reset_mem_addr", 256'(mem_addr_o), 256'(32'h0));
        chk("reset_mem_data", mem_data_o, 256'h0);
        chk("reset_cpu_data", 256'(cpu_data_o), 256'(32'h0));
        next_cycle();

        // Cold load: allocate only, ack on 3rd ALLOCATE cycle, 5 stall cycles.
        apply(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        serve_miss("cold", 1'b0, 32'h0, 0, 32'h0, 32'h0000_0100, 3, 5);
        @(negedge clk_i);
        chk("cold_retry_stall", 256'(cpu_stall_o), 256'(1'b0));
        chk("cold_retry_data", 256'(cpu_data_o), 256'(32'h0100_AAA1));
        next_cycle();

        // Hits, stores and idle cycles on the freshly filled line.
        foreach (hit_vecs[i]) begin
            apply(hit_vecs[i].req, hit_vecs[i].we, hit_vecs[i].addr, hit_vecs[i].wdata);
            @(negedge clk_i);
            chk($sformatf("vec%0d_stall", i), 256'(cpu_stall_o), 256'(hit_vecs[i].exp_stall));
            chk($sformatf("vec%0d_mem_req", i), 256'(mem_req_o), 256'(1'b0));
            if (hit_vecs[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), 256'(cpu_data_o), 256'(hit_vecs[i].exp_data));
            end
            next_cycle();
        end

        // Conflict on dirty index 8: write-back of the old line, then fetch.
        apply(1'b1, 1'b0, 32'h0000_0304, 32'h0);
        serve_miss("conflict", 1'b1, 32'h0000_0100, 1, 32'hDEAD_BEEF, 32'h0000_0300, 2, 5);
        @(negedge clk_i);
        chk("conflict_retry_stall", 256'(cpu_stall_o), 256'(1'b0));
        chk("conflict_retry_data", 256'(cpu_data_o), 256'(32'h0300_AAA1));
        next_cycle();

        // Store miss to invalid index 15: allocate, merge store on retry.
        apply(1'b1, 1'b1, 32'h0000_1FE0, 32'hCAFE_F00D);
        serve_miss("stmiss", 1'b0, 32'h0, 0, 32'h0, 32'h0000_1FE0, 1, 3);
        @(negedge clk_i);
        chk("stmiss_retry_stall", 256'(cpu_stall_o), 256'(1'b0));
        next_cycle();
        apply(1'b1, 1'b0, 32'h0000_1FE0, 32'h0);
        @(negedge clk_i);
        chk("stmiss_word0", 256'(cpu_data_o), 256'(32'hCAFE_F00D));
        next_cycle();
        apply(1'b1, 1'b0, 32'h0000_1FE4, 32'h0);
        @(negedge clk_i);
        chk("stmiss_word1", 256'(cpu_data_o), 256'(32'h1FE0_AAA1));
        next_cycle();
        // Dirty bit proven by the write-back of the merged line on a conflict.
        apply(1'b1, 1'b0, 32'h0000_3FE0, 32'h0);
        serve_miss("stmiss_evict", 1'b1, 32'h0000_1FE0, 0, 32'hCAFE_F00D, 32'h0000_3FE0, 1, 4);
        @(negedge clk_i);
        chk("stmiss_evict_data", 256'(cpu_data_o), 256'(32'h3FE0_AAA0));
        next_cycle();

        // Reset during ALLOCATE abandons the transaction and invalidates lines.
        apply(1'b1, 1'b0, 32'h0000_0504, 32'h0);
        @(negedge clk_i);
        chk("rstalloc_detect", 256'(cpu_stall_o), 256'(1'b1));
        next_cycle();
        @(negedge clk_i);
        chk("rstalloc_in_alloc", 256'({mem_req_o, mem_we_o}), 256'(2'b10));
        rst_i = 1'b1;
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstalloc_req_low", 256'(mem_req_o), 256'(1'b0));
        chk("rstalloc_stall_low", 256'(cpu_stall_o), 256'(1'b0));
        mem_ack_i  = 1'b1;
        mem_data_i = line_pat(32'h0000_0500);
        next_cycle();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("stray_ack_req", 256'(mem_req_o), 256'(1'b0));
        chk("stray_ack_stall", 256'(cpu_stall_o), 256'(1'b0));
        next_cycle();
        // 0x304 was a valid clean hit before reset; it must miss now.
        apply(1'b1, 1'b0, 32'h0000_0304, 32'h0);
        serve_miss("post_rst", 1'b0, 32'h0, 0, 32'h0, 32'h0000_0300, 1, 3);
        @(negedge clk_i);
        chk("post_rst_data", 256'(cpu_data_o), 256'(32'h0300_AAA1));
        next_cycle();
        apply(1'b0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
